// File: rtl/dn_mem_sched.sv
`timescale 1ns/1ps
// Routes HPS download bytes to BIOS/sprite/music memories one cycle after dn_wr and holds the core in reset around BIOS loads.
// CPU music-RAM access waits behind download strobes and music downloads; write ack 2 cycles after grant, read ack 3.
module dn_mem_sched #(
   parameter int ADDR_W       = 17,
   parameter int HOLD_CYCLES  = 16,
   parameter int BIOS_IDX_MAX = 1,
   parameter int SPR_IDX      = 3,
   parameter int MUS_IDX      = 4
) (
   input  logic              clk_24,
   input  logic              reset_n,
   input  logic              dn_download,
   input  logic              dn_wr,
   input  logic [7:0]        dn_index,
   input  logic [ADDR_W-1:0] dn_addr,
   input  logic [7:0]        dn_data,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic              cpu_ack,
   output logic [7:0]        cpu_dout,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_din,
   input  logic [7:0]        mem_q,
   output logic              bios_we,
   output logic              spr_we,
   output logic              mus_we,
   output logic              core_reset,
   output logic [2:0]        loaded,
   output logic [ADDR_W:0]   mus_len
);

   typedef enum logic [1:0] {T_NONE, T_BIOS, T_SPR, T_MUS} tgt_e;
   typedef enum logic [1:0] {RUN, DL, HOLD} rst_st_e;
   typedef enum logic [1:0] {AIDLE, ARD, AACK} arb_st_e;

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   function automatic tgt_e decode(input logic [7:0] idx);
      if (int'(idx) <= BIOS_IDX_MAX) return T_BIOS;
      if (int'(idx) == SPR_IDX)      return T_SPR;
      if (int'(idx) == MUS_IDX)      return T_MUS;
      return T_NONE;
   endfunction

   // Bit position in loaded: {music, sprite, bios}.
   function automatic logic [2:0] tgt_mask(input tgt_e t);
      case (t)
         T_BIOS:  return 3'b001;
         T_SPR:   return 3'b010;
         T_MUS:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   logic              dl_q;
   tgt_e              tgt_q;
   logic              wr_q;
   tgt_e              wr_tgt_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [7:0]        wr_data_q;
   logic [ADDR_W-1:0] port_addr_q;
   logic [7:0]        port_din_q;
   logic [2:0]        loaded_q, loaded_d;
   logic [ADDR_W:0]   mus_len_q, mus_len_d;
   rst_st_e           rst_st_q, rst_st_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   arb_st_e           arb_st_q, arb_st_d;
   logic              live_q;
   logic              ack_q;
   logic              rd_pend_q;
   logic [7:0]        rd_q;
   logic [7:0]        cpu_dout_q;

   tgt_e              idx_tgt;
   logic              dl_rise, dl_fall;
   logic              dn_strobe;
   logic              cpu_blocked;
   logic              grant;
   logic [ADDR_W:0]   wr_end;

   assign idx_tgt     = decode(dn_index);
   assign dl_rise     = dn_download & ~dl_q;
   assign dl_fall     = ~dn_download & dl_q;
   assign dn_strobe   = wr_q & (wr_tgt_q != T_NONE);
   assign cpu_blocked = dn_download & (idx_tgt == T_MUS);
   // ack_q keeps the still-held cpu_req of the finishing access from being granted twice.
   assign grant       = live_q & (arb_st_q == AIDLE) & cpu_req & ~dn_strobe & ~cpu_blocked & ~ack_q;
   assign wr_end      = {1'b0, wr_addr_q} + (ADDR_W+1)'(1);

   assign bios_we    = wr_q & (wr_tgt_q == T_BIOS);
   assign spr_we     = wr_q & (wr_tgt_q == T_SPR);
   assign mus_we     = (wr_q & (wr_tgt_q == T_MUS)) | (grant & cpu_we);
   assign core_reset = (rst_st_q != RUN);
   assign cpu_ack    = ack_q;
   assign cpu_dout   = cpu_dout_q;
   assign loaded     = loaded_q;
   assign mus_len    = mus_len_q;

   always_comb begin
      mem_addr = port_addr_q;
      mem_din  = port_din_q;
      if (dn_strobe) begin
         mem_addr = wr_addr_q;
         mem_din  = wr_data_q;
      end else if (grant) begin
         mem_addr = cpu_addr;
         if (cpu_we) mem_din = cpu_din;
      end
   end

   always_comb begin
      loaded_d  = loaded_q;
      mus_len_d = mus_len_q;
      if (dl_fall) loaded_d = loaded_d | tgt_mask(tgt_q);
      if (dl_rise) loaded_d = loaded_d & ~tgt_mask(idx_tgt);
      if (dl_rise && idx_tgt == T_MUS) begin
         mus_len_d = '0;
      end else if (wr_q && wr_tgt_q == T_MUS && wr_end > mus_len_q) begin
         mus_len_d = wr_end;
      end
   end

   always_comb begin
      rst_st_d = rst_st_q;
      cnt_d    = cnt_q;
      case (rst_st_q)
         RUN: begin
            if (dl_rise && idx_tgt == T_BIOS) rst_st_d = DL;
         end
         DL: begin
            if (dl_fall) begin
               rst_st_d = HOLD;
               cnt_d    = CNT_W'(HOLD_CYCLES);
            end
         end
         HOLD: begin
            if (dl_rise && idx_tgt == T_BIOS) begin
               rst_st_d = DL;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) rst_st_d = RUN;
            end
         end
         default: rst_st_d = RUN;
      endcase
   end

   always_comb begin
      arb_st_d = arb_st_q;
      case (arb_st_q)
         AIDLE:   if (grant) arb_st_d = cpu_we ? AACK : ARD;
         ARD:     arb_st_d = AACK;
         AACK:    arb_st_d = AIDLE;
         default: arb_st_d = AIDLE;
      endcase
   end

   always_ff @(posedge clk_24 or negedge reset_n) begin
      if (!reset_n) begin
         dl_q        <= 1'b0;
         tgt_q       <= T_NONE;
         wr_q        <= 1'b0;
         wr_tgt_q    <= T_NONE;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         port_addr_q <= '0;
         port_din_q  <= '0;
         loaded_q    <= '0;
         mus_len_q   <= '0;
         rst_st_q    <= RUN;
         cnt_q       <= '0;
         arb_st_q    <= AIDLE;
         live_q      <= 1'b0;
         ack_q       <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_q        <= '0;
         cpu_dout_q  <= '0;
      end else begin
         dl_q        <= dn_download;
         if (dl_rise) tgt_q <= idx_tgt;
         wr_q        <= dn_wr;
         if (dn_wr) begin
            wr_tgt_q  <= idx_tgt;
            wr_addr_q <= dn_addr;
            wr_data_q <= dn_data;
         end
         port_addr_q <= mem_addr;
         port_din_q  <= mem_din;
         loaded_q    <= loaded_d;
         mus_len_q   <= mus_len_d;
         rst_st_q    <= rst_st_d;
         cnt_q       <= cnt_d;
         arb_st_q    <= arb_st_d;
         live_q      <= 1'b1;
         ack_q       <= (arb_st_q == AACK);
         if (arb_st_q == ARD) begin
            rd_q      <= mem_q;
            rd_pend_q <= 1'b1;
         end
         // Read data is staged so cpu_dout only changes together with its ack.
         if (arb_st_q == AACK && rd_pend_q) begin
            cpu_dout_q <= rd_q;
            rd_pend_q  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dn_mem_sched.sv
`timescale 1ns/1ps
// Scoreboard bench for dn_mem_sched: directed scenarios followed by a randomized mix of downloads and CPU accesses.
module tb_dn_mem_sched;

   localparam int AW   = 17;
   localparam int HOLD = 16;

   logic          clk_24 = 1'b0;
   logic          reset_n = 1'b0;
   logic          dn_download = 1'b0;
   logic          dn_wr = 1'b0;
   logic [7:0]    dn_index = '0;
   logic [AW-1:0] dn_addr = '0;
   logic [7:0]    dn_data = '0;
   logic          cpu_req = 1'b0;
   logic          cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_din = '0;
   logic          cpu_ack;
   logic [7:0]    cpu_dout;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic [7:0]    mem_q;
   logic          bios_we, spr_we, mus_we, core_reset;
   logic [2:0]    loaded;
   logic [AW:0]   mus_len;

   always #5 clk_24 = ~clk_24;

   dn_mem_sched #(.ADDR_W(AW), .HOLD_CYCLES(HOLD), .BIOS_IDX_MAX(1), .SPR_IDX(3), .MUS_IDX(4)) dut (
      .clk_24(clk_24), .reset_n(reset_n),
      .dn_download(dn_download), .dn_wr(dn_wr), .dn_index(dn_index), .dn_addr(dn_addr), .dn_data(dn_data),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q),
      .bios_we(bios_we), .spr_we(spr_we), .mus_we(mus_we),
      .core_reset(core_reset), .loaded(loaded), .mus_len(mus_len)
   );

   // Music RAM device: registered read, 1-cycle latency.
   bit [7:0] ram [0:(1<<AW)-1];
   always @(posedge clk_24) begin
      mem_q <= ram[mem_addr];
      if (mus_we) ram[mem_addr] <= mem_din;
   end

   int cyc = 0;
   always @(posedge clk_24) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model state
   typedef struct { int tgt; logic [AW-1:0] addr; logic [7:0] data; int cyc; } strb_t;
   typedef struct { bit we; logic [7:0] data; } cpu_t;
   strb_t    sq[$];
   cpu_t     cq[$];
   bit [7:0] ref_mus [0:255];
   bit [2:0] m_loaded = '0;
   int       m_len = 0;
   int       bios_rise = -1;
   int       bios_fall = -1;
   int       cur_tgt = -1;

   function automatic int tgt_of(input logic [7:0] idx);
      if (idx <= 8'd1) return 0;
      if (idx == 8'd3) return 1;
      if (idx == 8'd4) return 2;
      return -1;
   endfunction

   // Monitor: strobes, CPU acks and core_reset checked every cycle on the falling edge.
   int    mon_ns, mon_ta;
   strb_t mon_e;
   cpu_t  mon_c;
   bit    exp_cr;
   always @(negedge clk_24) begin
      if (reset_n) begin
         mon_ns = int'(bios_we) + int'(spr_we) + int'(mus_we);
         chk("strobe_onehot", 32'(mon_ns <= 1), 32'd1);
         if (mon_ns != 0) begin
            mon_ta = bios_we ? 0 : (spr_we ? 1 : 2);
            if (sq.size() == 0) begin
               chk("strobe_expected", 32'(mon_ta), 32'hFFFF_FFFF);
            end else begin
               mon_e = sq.pop_front();
               chk("strobe_tgt", 32'(mon_ta), 32'(mon_e.tgt));
               chk("strobe_addr", 32'(mem_addr), 32'(mon_e.addr));
               chk("strobe_data", 32'(mem_din), 32'(mon_e.data));
               chk("strobe_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
         end
         if (cpu_ack) begin
            if (cq.size() == 0) begin
               chk("ack_expected", 32'd1, 32'd0);
            end else begin
               mon_c = cq.pop_front();
               if (!mon_c.we) chk("cpu_dout", 32'(cpu_dout), 32'(mon_c.data));
            end
         end
         exp_cr = (bios_rise >= 0) && (cyc > bios_rise) &&
                  ((bios_fall < bios_rise) || (cyc <= bios_fall + HOLD));
         chk("core_reset", 32'(core_reset), 32'(exp_cr));
      end
   end

   task automatic step();
      @(posedge clk_24);
      #1;
   endtask

   task automatic dl_start(input logic [7:0] idx);
      dn_download = 1'b1;
      dn_index    = idx;
      cur_tgt     = tgt_of(idx);
      if (cur_tgt >= 0) m_loaded[cur_tgt] = 1'b0;
      if (cur_tgt == 2) m_len = 0;
      if (cur_tgt == 0) bios_rise = cyc;
      step();
   endtask

   task automatic dl_byte(input logic [AW-1:0] a, input logic [7:0] d, input int gap);
      dn_wr   = 1'b1;
      dn_addr = a;
      dn_data = d;
      if (cur_tgt >= 0) sq.push_back('{cur_tgt, a, d, cyc + 1});
      if (cur_tgt == 2) begin
         ref_mus[a[7:0]] = d;
         if (int'(a) + 1 > m_len) m_len = int'(a) + 1;
      end
      step();
      dn_wr = 1'b0;
      repeat (gap) step();
   endtask

   task automatic dl_end();
      dn_download = 1'b0;
      if (cur_tgt == 0) bios_fall = cyc;
      if (cur_tgt >= 0) m_loaded[cur_tgt] = 1'b1;
      cur_tgt = -1;
      step();
      step();
      chk("loaded", 32'(loaded), 32'(m_loaded));
      chk("mus_len", 32'(mus_len), 32'(m_len));
   endtask

   task automatic cpu_issue(input bit we, input logic [AW-1:0] a, input logic [7:0] d, output int c);
      cpu_req  = 1'b1;
      cpu_we   = we;
      cpu_addr = a;
      cpu_din  = d;
      c        = cyc;
      if (we) begin
         ref_mus[a[7:0]] = d;
         sq.push_back('{2, a, d, cyc});
         cq.push_back('{1'b1, 8'h00});
      end else begin
         cq.push_back('{1'b0, ref_mus[a[7:0]]});
      end
   endtask

   task automatic cpu_wait(output int a_cyc);
      bit got = 1'b0;
      a_cyc = -1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk_24);
         if (cpu_ack) begin
            got   = 1'b1;
            a_cyc = cyc;
         end
      end
      chk("cpu_ack_seen", 32'(got), 32'd1);
      step();
      cpu_req = 1'b0;
   endtask

   task automatic cpu_op(input bit we, input logic [AW-1:0] a, input logic [7:0] d);
      int c, ac;
      cpu_issue(we, a, d, c);
      cpu_wait(ac);
      chk(we ? "write_ack_latency" : "read_ack_latency", 32'(ac - c), we ? 32'd2 : 32'd3);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   logic [7:0] idx_tab [0:6];
   initial begin
      int c, ac, f, op, n;
      idx_tab[0] = 8'd0; idx_tab[1] = 8'd1; idx_tab[2] = 8'd3; idx_tab[3] = 8'd4;
      idx_tab[4] = 8'd7; idx_tab[5] = 8'd2; idx_tab[6] = 8'd200;

      repeat (3) @(posedge clk_24);
      #1;
      chk("rst_core_reset", 32'(core_reset), 32'd0);
      chk("rst_loaded", 32'(loaded), 32'd0);
      chk("rst_mus_len", 32'(mus_len), 32'd0);
      chk("rst_ack", 32'(cpu_ack), 32'd0);
      chk("rst_dout", 32'(cpu_dout), 32'd0);
      chk("rst_strobes", 32'({bios_we, spr_we, mus_we}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_din", 32'(mem_din), 32'd0);
      reset_n = 1'b1;
      step();

      // BIOS download, bytes 0..3 with one back-to-back pair
      dl_start(8'd0);
      for (int i = 0; i < 4; i++) dl_byte(AW'(i), 8'(8'hB0 + i), (i == 1) ? 0 : 1);
      dl_end();
      repeat (20) step();

      // Second BIOS load, reset asserted with the hold counter at 5
      dl_start(8'd1);
      dl_byte(AW'(8), 8'hE7, 1);
      dl_end();
      repeat (10) step();
      #2;
      reset_n   = 1'b0;
      m_loaded  = '0;
      m_len     = 0;
      bios_rise = -1;
      bios_fall = -1;
      #1;
      chk("midhold_core_reset", 32'(core_reset), 32'd0);
      chk("midhold_loaded", 32'(loaded), 32'd0);
      chk("midhold_mus_len", 32'(mus_len), 32'd0);
      step();
      reset_n = 1'b1;
      repeat (20) step();

      // CPU write then read-back
      cpu_op(1'b1, AW'('h10), 8'h5A);
      cpu_op(1'b0, AW'('h10), 8'h00);

      // Short music load, then the main one with a CPU read held off until it ends
      dl_start(8'd4);
      dl_byte(AW'(9), 8'h99, 1);
      dl_end();
      dl_start(8'd4);
      chk("mus_start_loaded", 32'(loaded), 32'(m_loaded));
      chk("mus_start_len", 32'(mus_len), 32'd0);
      dl_byte(AW'(0), 8'h11, 1);
      cpu_issue(1'b0, AW'('h10), 8'h00, c);
      dl_byte(AW'(5), 8'h55, 1);
      dl_byte(AW'(2), 8'h22, 1);
      f = cyc;
      dl_end();
      chk("mus_len_six", 32'(mus_len), 32'd6);
      cpu_wait(ac);
      chk("blocked_read_ack_cycle", 32'(ac), 32'(f + 3));

      // Sprite strobe and CPU read request in the same cycle
      dl_start(8'd3);
      dn_wr   = 1'b1;
      dn_addr = AW'('h30);
      dn_data = 8'hC3;
      sq.push_back('{1, AW'('h30), 8'hC3, cyc + 1});
      step();
      dn_wr = 1'b0;
      cpu_issue(1'b0, AW'('h10), 8'h00, c);
      step();
      @(negedge clk_24);
      chk("grant_after_strobe_addr", 32'(mem_addr), 32'h10);
      cpu_wait(ac);
      chk("grant_after_strobe_ack", 32'(ac - c), 32'd4);
      dl_end();

      // Unmapped index: nothing may change
      dl_start(8'd7);
      for (int i = 0; i < 3; i++) dl_byte(AW'(i + 40), 8'(i + 1), 1);
      dl_end();

      // Randomized mix
      for (int k = 0; k < 40; k++) begin
         op = int'($urandom_range(0, 2));
         if (op == 0) begin
            dl_start(idx_tab[$urandom_range(0, 6)]);
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++)
               dl_byte(AW'($urandom_range(0, 63)), 8'($urandom), int'($urandom_range(0, 2)));
            dl_end();
         end else begin
            cpu_op(op == 1, AW'($urandom_range(0, 63)), 8'($urandom));
         end
         repeat ($urandom_range(0, 3)) step();
      end

      repeat (30) step();
      chk("strobe_queue_drained", 32'(sq.size()), 32'd0);
      chk("cpu_queue_drained", 32'(cq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
